// File: rtl/fp_round_pkg.sv
// Shared definitions for the floating-point rounding pipeline.
// Covers the rounding-mode encodings and the guard/round/sticky bit positions.
package fp_round_pkg;

    typedef enum logic [1:0] {
        MODE_RNE = 2'd0,
        MODE_RTZ = 2'd1,
        MODE_RUP = 2'd2,
        MODE_RDN = 2'd3
    } round_mode_e;

    // The GRS field sits in the low bits of the unrounded word.
    localparam int GRS_W = 3;
    localparam int GRS_S = 0;
    localparam int GRS_R = 1;
    localparam int GRS_G = 2;

endpackage

// File: rtl/fp_round_dec.sv
// Combinational rounding decision.
// Produces the increment and inexact indications from sign, mantissa LSB, GRS and mode.
module fp_round_dec
    import fp_round_pkg::*;
(
    input  logic             sign,
    input  logic             lsb,
    input  logic [GRS_W-1:0] grs,
    input  logic [1:0]       mode,
    output logic             inc,
    output logic             inexact
);

    always_comb begin
        inexact = |grs;
        inc     = 1'b0;
        case (round_mode_e'(mode))
            MODE_RNE: inc = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | lsb);
            MODE_RTZ: inc = 1'b0;
            MODE_RUP: inc = ~sign & inexact;
            MODE_RDN: inc = sign & inexact;
            default:  inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage valid/ready rounding pipeline: stage 1 decides the increment,
// stage 2 applies it, detects overflow to infinity and counts inexact results.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter  int EXP_W  = 8,
    parameter  int MAN_W  = 23,
    parameter  int CNT_W  = 16,
    localparam int DATA_W = 1 + EXP_W + MAN_W + GRS_W,
    localparam int OUT_W  = 1 + EXP_W + MAN_W,
    localparam int EM_W   = EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_inexact,
    output logic              out_overflow,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  inexact_cnt
);

    logic             in_sign;
    logic [EM_W-1:0]  in_em;
    logic [EXP_W-1:0] in_exp;
    logic [GRS_W-1:0] in_grs;
    logic             in_special;
    logic             dec_inc;
    logic             dec_inexact;

    logic             s1_valid_q,   s1_valid_d;
    logic             s1_sign_q,    s1_sign_d;
    logic [EM_W-1:0]  s1_em_q,      s1_em_d;
    logic             s1_inc_q,     s1_inc_d;
    logic             s1_inexact_q, s1_inexact_d;
    logic             s1_special_q, s1_special_d;

    logic             out_valid_q,    out_valid_d;
    logic [OUT_W-1:0] out_data_q,     out_data_d;
    logic             out_inexact_q,  out_inexact_d;
    logic             out_overflow_q, out_overflow_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;

    logic             s2_adv;
    logic             in_fire;
    logic [EM_W-1:0]  sum;
    logic             sum_ovf;

    assign in_sign    = in_data[DATA_W-1];
    assign in_em      = in_data[GRS_W +: EM_W];
    assign in_exp     = in_data[GRS_W + MAN_W +: EXP_W];
    assign in_grs     = in_data[GRS_W-1:0];
    assign in_special = &in_exp;

    fp_round_dec u_dec (
        .sign    (in_sign),
        .lsb     (in_data[GRS_W]),
        .grs     (in_grs),
        .mode    (in_mode),
        .inc     (dec_inc),
        .inexact (dec_inexact)
    );

    always_comb begin
        s2_adv   = ~out_valid_q | out_ready;
        // rst_n gates ready so nothing is accepted while reset is held.
        in_ready = rst_n & (~s1_valid_q | s2_adv);
        in_fire  = in_valid & in_ready;

        s1_valid_d   = in_fire | (s1_valid_q & ~s2_adv);
        s1_sign_d    = s1_sign_q;
        s1_em_d      = s1_em_q;
        s1_inc_d     = s1_inc_q;
        s1_inexact_d = s1_inexact_q;
        s1_special_d = s1_special_q;
        if (in_fire) begin
            s1_sign_d    = in_sign;
            s1_em_d      = in_em;
            s1_inc_d     = dec_inc & ~in_special;
            s1_inexact_d = dec_inexact & ~in_special;
            s1_special_d = in_special;
        end

        sum     = s1_em_q + EM_W'(s1_inc_q);
        sum_ovf = (&sum[EM_W-1 -: EXP_W]) & ~s1_special_q;

        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_inexact_d  = out_inexact_q;
        out_overflow_d = out_overflow_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d     = sum_ovf ? {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                         : {s1_sign_q, sum};
                out_inexact_d  = s1_inexact_q;
                out_overflow_d = sum_ovf;
            end
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q & out_ready & out_inexact_q & ~(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_em_q        <= '0;
            s1_inc_q       <= 1'b0;
            s1_inexact_q   <= 1'b0;
            s1_special_q   <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_inexact_q  <= 1'b0;
            out_overflow_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sign_q      <= s1_sign_d;
            s1_em_q        <= s1_em_d;
            s1_inc_q       <= s1_inc_d;
            s1_inexact_q   <= s1_inexact_d;
            s1_special_q   <= s1_special_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_inexact_q  <= out_inexact_d;
            out_overflow_q <= out_overflow_d;
            cnt_q          <= cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_inexact  = out_inexact_q;
    assign out_overflow = out_overflow_q;
    assign inexact_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed self-checking bench for fp_round_pipe with hand-computed expectations.
module tb_fp_round_pipe;

    localparam logic [1:0] RNE = 2'd0;
    localparam logic [1:0] RTZ = 2'd1;
    localparam logic [1:0] RUP = 2'd2;
    localparam logic [1:0] RDN = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;
    logic        out_overflow;
    logic        cnt_clr;
    logic [15:0] inexact_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    fp_round_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow),
        .cnt_clr      (cnt_clr),
        .inexact_cnt  (inexact_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [34:0] mkw(input logic s, input logic [7:0] e,
                                        input logic [22:0] m, input logic [2:0] g);
        return {s, e, m, g};
    endfunction

    function automatic logic [31:0] mko(input logic s, input logic [7:0] e, input logic [22:0] m);
        return {s, e, m};
    endfunction

    // One word through an empty pipe: checks latency, result, flags and the counter.
    task automatic send_one(input string tag, input logic [34:0] w, input logic [1:0] m,
                            input logic [31:0] want, input logic inx, input logic ovf,
                            input logic clr);
        @(negedge clk);
        in_valid = 1'b1; in_data = w; in_mode = m; out_ready = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_data"}, out_data, want);
        check_eq({tag, "_inexact"}, out_inexact, inx);
        check_eq({tag, "_overflow"}, out_overflow, ovf);
        cnt_clr = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_cnt = clr ? 0 : exp_cnt + int'(inx);
        check_eq({tag, "_cnt"}, inexact_cnt, exp_cnt);
        check_eq({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        logic [34:0] bw [4];
        logic [31:0] bo [4];
        int sent;
        int recv;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = RNE;
        out_ready = 1'b1; cnt_clr = 1'b0;
        #3;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_flags", {out_inexact, out_overflow}, 0);
        check_eq("rst_cnt", inexact_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", in_ready, 1);

        send_one("rne_tie_even", mkw(0, 8'h82, 23'h000200, 3'b100), RNE,
                 mko(0, 8'h82, 23'h000200), 1, 0, 0);
        send_one("rne_tie_odd", mkw(0, 8'h82, 23'h000201, 3'b100), RNE,
                 mko(0, 8'h82, 23'h000202), 1, 0, 0);
        send_one("rne_carry", mkw(0, 8'h82, 23'h7FFFFF, 3'b100), RNE,
                 mko(0, 8'h83, 23'h000000), 1, 0, 0);
        send_one("rup_ovf", mkw(0, 8'hFE, 23'h7FFFFF, 3'b111), RUP,
                 mko(0, 8'hFF, 23'h000000), 1, 1, 0);
        send_one("rtz_trunc", mkw(0, 8'hFE, 23'h7FFFFF, 3'b111), RTZ,
                 mko(0, 8'hFE, 23'h7FFFFF), 1, 0, 0);
        check_eq("cnt_five", inexact_cnt, 5);
        send_one("rdn_neg_ovf", mkw(1, 8'hFE, 23'h7FFFFF, 3'b111), RDN,
                 mko(1, 8'hFF, 23'h000000), 1, 1, 0);
        send_one("rup_neg", mkw(1, 8'h40, 23'h000010, 3'b001), RUP,
                 mko(1, 8'h40, 23'h000010), 1, 0, 0);
        send_one("rdn_pos", mkw(0, 8'h40, 23'h000010, 3'b010), RDN,
                 mko(0, 8'h40, 23'h000010), 1, 0, 0);
        send_one("rdn_neg_inc", mkw(1, 8'h40, 23'h000010, 3'b001), RDN,
                 mko(1, 8'h40, 23'h000011), 1, 0, 0);
        send_one("rne_below_half", mkw(0, 8'h40, 23'h000011, 3'b011), RNE,
                 mko(0, 8'h40, 23'h000011), 1, 0, 0);
        send_one("rne_above_half", mkw(0, 8'h40, 23'h000010, 3'b110), RNE,
                 mko(0, 8'h40, 23'h000011), 1, 0, 0);
        send_one("exact_rup", mkw(0, 8'h40, 23'h000010, 3'b000), RUP,
                 mko(0, 8'h40, 23'h000010), 0, 0, 0);
        send_one("nan_pass", mkw(0, 8'hFF, 23'h400000, 3'b111), RUP,
                 mko(0, 8'hFF, 23'h400000), 0, 0, 0);
        send_one("clr_wins", mkw(0, 8'h40, 23'h000010, 3'b111), RUP,
                 mko(0, 8'h40, 23'h000011), 1, 0, 1);
        send_one("after_clr", mkw(0, 8'h40, 23'h000010, 3'b100), RUP,
                 mko(0, 8'h40, 23'h000011), 1, 0, 0);

        // Back-pressure: two words fill the pipe, the rest wait for out_ready.
        for (int i = 0; i < 4; i++) begin
            bw[i] = mkw(0, 8'h10, 23'(i + 1), 3'b000);
            bo[i] = mko(0, 8'h10, 23'(i + 1));
        end
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) in_data = bw[sent];
            in_mode = RTZ;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check_eq("bp_in_ready_low", in_ready, 0);
                check_eq("bp_held_valid", out_valid, 1);
                check_eq("bp_held_data", out_data, bo[0]);
            end
            if (out_valid && out_ready) begin
                check_eq("bp_order", out_data, bo[recv]);
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        check_eq("bp_recv", recv, 4);
        check_eq("bp_sent", sent, 4);
        @(negedge clk);
        check_eq("bp_no_dup", out_valid, 0);
        check_eq("bp_cnt", inexact_cnt, exp_cnt);

        // Reset with both stages holding inexact words.
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = RUP; in_data = mkw(0, 8'h20, 23'h000001, 3'b111);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_valid", out_valid, 1);
        check_eq("pre_rst_cnt", inexact_cnt, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_cnt", inexact_cnt, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_valid", out_valid, 0);
        check_eq("post_rst_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
